// File: rtl/misao_fetch_queue.sv
// Nibble-granular instruction prefetch queue: byte fetch into a circular FIFO, nibble presentation to the decoder.
// Optional performance counters enabled by defining MISAO_FETCH_PERF_EN.
module misao_fetch_queue #(
    parameter int unsigned ADDR_W   = 15,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_enable_read,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data_in,
    input  logic              fetch_hold,
    input  logic              redirect_valid,
    input  logic [ADDR_W:0]   redirect_pc,
    output logic              nib_valid,
    input  logic              nib_ready,
    output logic [3:0]        nib_data,
    output logic [ADDR_W:0]   nib_pc,
    output logic [15:0]       perf_fetch_cnt,
    output logic [15:0]       perf_flush_cnt
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned NPC_W = ADDR_W + 1;
    localparam logic [NPC_W-1:0] RESET_NPC = NPC_W'(RESET_PC);

    logic [7:0]        data_q [DEPTH];
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] fetch_addr;
    logic              nsel;
    logic              push;
    logic              hs;
    logic              pop;
    logic [7:0]        head_byte;

    // Fetch request and decoder-side handshake decode
    always_comb begin
        push            = (count < CNT_W'(DEPTH)) && !fetch_hold && !redirect_valid && !rst;
        mem_enable_read = push;
        mem_addr        = fetch_addr;
        nib_valid       = (count != '0);
        head_byte       = data_q[rd_ptr];
        nib_data        = nsel ? head_byte[7:4] : head_byte[3:0];
        nib_pc          = {addr_q[rd_ptr], nsel};
        hs              = nib_valid && nib_ready;
        pop             = hs && nsel;
    end

    // Queue storage carries no reset; validity is tracked by count
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr] <= mem_data_in;
            addr_q[wr_ptr] <= fetch_addr;
        end
    end

    // Pointers, occupancy, fetch address and nibble select; redirect overrides push/pop
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            fetch_addr <= RESET_NPC[ADDR_W:1];
            nsel       <= RESET_NPC[0];
        end else if (redirect_valid) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            fetch_addr <= redirect_pc[ADDR_W:1];
            nsel       <= redirect_pc[0];
        end else begin
            if (push) begin
                wr_ptr     <= wr_ptr + PTR_W'(1);
                fetch_addr <= fetch_addr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (hs) begin
                nsel <= ~nsel;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

`ifdef MISAO_FETCH_PERF_EN
    logic [15:0] fetch_cnt_q;
    logic [15:0] flush_cnt_q;

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (push && (fetch_cnt_q != 16'hFFFF)) begin
                fetch_cnt_q <= fetch_cnt_q + 16'd1;
            end
            if (redirect_valid && (flush_cnt_q != 16'hFFFF)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`else
    assign perf_fetch_cnt = 16'd0;
    assign perf_flush_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_misao_fetch_queue.sv
// Directed self-checking bench for misao_fetch_queue; a second instance covers the address wrap from RESET_PC=0xFFFE.
module tb_misao_fetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_hold = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        nib_ready = 1'b0;

    logic        mem_enable_read, mem_enable_read2;
    logic [14:0] mem_addr, mem_addr2;
    logic [7:0]  mem_data_in, mem_data_in2;
    logic        nib_valid, nib_valid2;
    logic [3:0]  nib_data, nib_data2;
    logic [15:0] nib_pc, nib_pc2;
    logic [15:0] perf_fetch_cnt, perf_flush_cnt, perf_fetch_cnt2, perf_flush_cnt2;

    int checks = 0;
    int failures = 0;
    int reads;

    always #5 clk = ~clk;

    // Memory image: bytes 0..3 are 21,43,65,87; elsewhere low address byte XOR A5
    function automatic logic [7:0] mem_byte(input logic [14:0] a);
        logic [7:0] img [4];
        img[0] = 8'h21; img[1] = 8'h43; img[2] = 8'h65; img[3] = 8'h87;
        if (a < 15'd4) return img[a[1:0]];
        return a[7:0] ^ 8'hA5;
    endfunction

    assign mem_data_in  = mem_byte(mem_addr);
    assign mem_data_in2 = mem_byte(mem_addr2);

    misao_fetch_queue #(.ADDR_W(15), .DEPTH(4), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst),
        .mem_enable_read(mem_enable_read), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .fetch_hold(fetch_hold), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .nib_valid(nib_valid), .nib_ready(nib_ready), .nib_data(nib_data), .nib_pc(nib_pc),
        .perf_fetch_cnt(perf_fetch_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    misao_fetch_queue #(.ADDR_W(15), .DEPTH(4), .RESET_PC(16'hFFFE)) dut_wrap (
        .clk(clk), .rst(rst),
        .mem_enable_read(mem_enable_read2), .mem_addr(mem_addr2), .mem_data_in(mem_data_in2),
        .fetch_hold(fetch_hold), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .nib_valid(nib_valid2), .nib_ready(nib_ready), .nib_data(nib_data2), .nib_pc(nib_pc2),
        .perf_fetch_cnt(perf_fetch_cnt2), .perf_flush_cnt(perf_flush_cnt2)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle without changing inputs, land 2 time units after the edge
    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    // Hold reset for two edges, release it; returns inside cycle 0 (first cycle with rst=0)
    task automatic do_reset(input logic ready);
        @(posedge clk);
        #1;
        rst = 1'b1;
        nib_ready = ready;
        fetch_hold = 1'b0;
        redirect_valid = 1'b0;
        #1;
        check("rst_no_read", int'(mem_enable_read), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        // Stream from reset, with wrap instance in parallel
        do_reset(1'b1);
        check("rst_nib_valid", int'(nib_valid), 0);
        check("c0_read", int'(mem_enable_read), 1);
        check("c0_addr", int'(mem_addr), 0);
        check("wrap_c0_addr", int'(mem_addr2), 'h7FFF);
        for (int i = 1; i <= 8; i++) begin
            nxt();
            check("stream_valid", int'(nib_valid), 1);
            check("stream_data", int'(nib_data), i);
            check("stream_pc", int'(nib_pc), i - 1);
            if (i == 1) begin
                check("wrap_addr", int'(mem_addr2), 0);
                check("wrap_pc0", int'(nib_pc2), 'hFFFE);
                check("wrap_data0", int'(nib_data2), 'hA);
            end else if (i == 2) begin
                check("wrap_pc1", int'(nib_pc2), 'hFFFF);
                check("wrap_data1", int'(nib_data2), 'h5);
            end else if (i == 3) begin
                check("wrap_pc2", int'(nib_pc2), 0);
                check("wrap_data2", int'(nib_data2), 1);
            end
        end

        // Backpressure: mid-stream reset then no consumption
        do_reset(1'b0);
        check("bp_flushed", int'(nib_valid), 0);
        reads = int'(mem_enable_read);
        for (int i = 0; i < 7; i++) begin
            nxt();
            reads += int'(mem_enable_read);
        end
        check("bp_reads", reads, 4);
        check("bp_no_read", int'(mem_enable_read), 0);
        check("bp_count", int'(dut.count), 4);
        check("bp_data", int'(nib_data), 1);
        check("bp_pc", int'(nib_pc), 0);

        // Odd redirect from a full queue
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc = 16'h003D;
        #1;
        check("redir_no_read", int'(mem_enable_read), 0);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        #1;
        check("redir_n1_valid", int'(nib_valid), 0);
        check("redir_n1_read", int'(mem_enable_read), 1);
        check("redir_n1_addr", int'(mem_addr), 'h1E);
`ifdef MISAO_FETCH_PERF_EN
        check("perf_flush1", int'(perf_flush_cnt), 1);
`else
        check("perf_flush_tied", int'(perf_flush_cnt), 0);
        check("perf_fetch_tied", int'(perf_fetch_cnt), 0);
`endif
        nxt();
        check("redir_n2_valid", int'(nib_valid), 1);
        check("redir_n2_pc", int'(nib_pc), 'h3D);
        check("redir_n2_data", int'(nib_data), 'hB);
        nxt();

        // Redirect together with a handshake at count=3
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc = 16'h0010;
        nib_ready = 1'b1;
        #1;
        check("rh_count3", int'(dut.count), 3);
        check("rh_valid", int'(nib_valid), 1);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        #1;
        check("rh_flushed", int'(dut.count), 0);
        check("rh_no_stale", int'(nib_valid), 0);
`ifdef MISAO_FETCH_PERF_EN
        check("perf_flush2", int'(perf_flush_cnt), 2);
`endif
        nxt();
        check("rh_pc", int'(nib_pc), 'h10);
        check("rh_data", int'(nib_data), 'hD);

        // Back-to-back redirects: last one wins
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc = 16'h0020;
        @(posedge clk); #1;
        redirect_pc = 16'h0031;
        #1;
        check("b2b_gap0", int'(nib_valid), 0);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        #1;
        check("b2b_gap1", int'(nib_valid), 0);
        check("b2b_addr", int'(mem_addr), 'h18);
        nxt();
        check("b2b_pc", int'(nib_pc), 'h31);
        check("b2b_data", int'(nib_data), 'hB);

        // fetch_hold for three cycles while draining
        do_reset(1'b1);
        check("hold_c0_read", int'(mem_enable_read), 1);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            fetch_hold = 1'b1;
            #1;
            check("hold_no_read", int'(mem_enable_read), 0);
            if (i < 3) check("hold_data", int'(nib_data), i);
        end
        check("hold_drained", int'(nib_valid), 0);
        @(posedge clk); #1;
        fetch_hold = 1'b0;
        #1;
        check("hold_resume_read", int'(mem_enable_read), 1);
        check("hold_resume_addr", int'(mem_addr), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
